// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive FIFO: status bit positions in the CPU read word.
package uart_rx_fifo_pkg;

    localparam int RX_BYTE_W    = 8;
    localparam int RX_ST_NEMPTY = 8;
    localparam int RX_ST_OVR    = 9;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the CPU bus, with show-ahead read data,
// sticky overrun and a level interrupt on fill threshold or idle timeout.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int IRQ_THRESH  = 8,
    parameter int TIMEOUT_CYC = 2700,
    parameter int CPU_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [RX_BYTE_W-1:0]     rx_data,
    input  logic                     rd_en,
    input  logic                     clr_ovr,
    output logic [CPU_WIDTH-1:0]     rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     irq_rx
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(IRQ_THRESH);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC);

    logic [RX_BYTE_W-1:0] mem [DEPTH];
    logic [PW-1:0]        wp;
    logic [PW-1:0]        rp;
    logic [TW-1:0]        idle_left;
    logic                 ovr;
    logic                 push_ok;
    logic                 pop_ok;
    logic                 drop;
    logic                 tmo;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    // A pop on a full FIFO frees the slot the coincident push needs.
    assign push_ok = rx_valid && (!full || rd_en);
    assign pop_ok  = rd_en && !empty;
    assign drop    = rx_valid && full && !rd_en;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wp] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            idle_left <= TMO_LOAD;
            ovr       <= 1'b0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop_ok)  rp <= rp + 1'b1;

            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // A new overflow wins over a coincident clear.
            if (drop) begin
                ovr <= 1'b1;
            end else if (clr_ovr) begin
                ovr <= 1'b0;
            end

            // Idle timer counts down from the timeout; reaching zero with data pending is the timeout.
            if (empty || push_ok || pop_ok) begin
                idle_left <= TMO_LOAD;
            end else if (idle_left != '0) begin
                idle_left <= idle_left - 1'b1;
            end
        end
    end

    assign tmo    = !empty && (idle_left == '0);
    assign irq_rx = (count >= THRESH_C) || tmo;

    // Head byte is masked while empty so the word reads zero out of reset.
    always_comb begin
        rd_data = '0;
        if (!empty) begin
            rd_data[RX_BYTE_W-1:0] = mem[rp];
        end
        rd_data[RX_ST_NEMPTY] = !empty;
        rd_data[RX_ST_OVR]    = ovr;
    end

endmodule
